// File: rtl/xc_aes_pkg.sv
// Shared constants for the sequenced AES sub-bytes unit: S-box tables,
// FSM state encoding and operand byte-select positions.
package xc_aes_pkg;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_BUSY = 2'd1;
    localparam state_t ST_DONE = 2'd2;

    // LSB of each selected byte: b0/b2 come from rs1, b1/b3 from rs2.
    localparam int SEL_B0_LSB = 0;
    localparam int SEL_B1_LSB = 8;
    localparam int SEL_B2_LSB = 16;
    localparam int SEL_B3_LSB = 24;

    localparam logic [7:0] SBOX_FWD [0:255] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    localparam logic [7:0] SBOX_INV [0:255] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

endpackage

// File: rtl/xc_aessub_seq_if.sv
// Request/response bundle between the execute stage and the sequenced
// aessub unit.
interface xc_aessub_seq_if;
    // valid is held high by the requester until the one-cycle ready pulse;
    // result is meaningful only while ready is high. flush aborts anything
    // in flight and blocks a same-cycle accept.
    logic        valid;
    logic        flush;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        enc;
    logic        rot;
    logic        ready;
    logic [31:0] result;

    modport master (output valid, flush, rs1, rs2, enc, rot, input ready, result);
    modport slave  (input valid, flush, rs1, rs2, enc, rot, output ready, result);
endinterface

// File: rtl/xc_aes_sbox.sv
// Single-byte AES S-box: forward when enc=1, inverse when enc=0.
module xc_aes_sbox
    import xc_aes_pkg::*;
(
    input  logic [7:0] x,
    input  logic       enc,
    output logic [7:0] y
);
    assign y = enc ? SBOX_FWD[x] : SBOX_INV[x];
endmodule

// File: rtl/xc_aessub_seq.sv
// Multi-cycle xc.aessub: BPC S-boxes sweep the four selected bytes over 4/BPC cycles.
// Build option XC_AESSUB_SEQ_RESULT_CLEAR_EN zeroes result when idle and scrubs buffers.
module xc_aessub_seq
    import xc_aes_pkg::*;
#(
    parameter int BPC = 1
) (
    input  logic           g_clk,
    input  logic           g_resetn,
    xc_aessub_seq_if.slave bus,
    output state_t         fsm_state
);

    localparam logic [1:0] STEP = 2'(BPC);
    localparam logic [1:0] LAST = 2'(4 - BPC);

    state_t          state;
    state_t          state_nxt;
    logic [1:0]      cnt;
    logic [3:0][7:0] op_b;
    logic [3:0][7:0] sbuf;
    logic            op_enc;
    logic            op_rot;
    logic [3:0][7:0] sel_b;
    logic            accept;
    logic            busy_step;
    logic            last_grp;
    logic [31:0]     rot_val;
    logic            unused_bits;

    assign sel_b = {bus.rs2[SEL_B3_LSB +: 8], bus.rs1[SEL_B2_LSB +: 8],
                    bus.rs2[SEL_B1_LSB +: 8], bus.rs1[SEL_B0_LSB +: 8]};
    assign unused_bits = ^{bus.rs1[31:24], bus.rs1[15:8], bus.rs2[23:16], bus.rs2[7:0]};

    assign accept    = (state == ST_IDLE) && bus.valid && !bus.flush;
    assign busy_step = (state == ST_BUSY) && !bus.flush;
    assign last_grp  = (cnt == LAST);

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (bus.valid) state_nxt = ST_BUSY;
            ST_BUSY: if (last_grp) state_nxt = ST_DONE;
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
        if (bus.flush) state_nxt = ST_IDLE;
    end

    // Group g handles byte cnt+g; cnt steps by BPC so groups never overlap.
    logic [BPC-1:0][1:0] sb_idx;
    logic [BPC-1:0][7:0] sb_out;

    for (genvar g = 0; g < BPC; g++) begin : g_sbox
        assign sb_idx[g] = cnt + 2'(g);
        xc_aes_sbox u_sbox (
            .x   (op_b[sb_idx[g]]),
            .enc (op_enc),
            .y   (sb_out[g])
        );
    end

    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            op_b   <= '0;
            op_enc <= 1'b0;
            op_rot <= 1'b0;
            sbuf   <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                op_b   <= sel_b;
                op_enc <= bus.enc;
                op_rot <= bus.rot;
                cnt    <= '0;
            end else if (busy_step) begin
                for (int g = 0; g < BPC; g++) sbuf[sb_idx[g]] <= sb_out[g];
                if (!last_grp) cnt <= cnt + STEP;
            end
            if (state_nxt == ST_IDLE) begin
                cnt <= '0;
`ifdef XC_AESSUB_SEQ_RESULT_CLEAR_EN
                op_b   <= '0;
                op_enc <= 1'b0;
                op_rot <= 1'b0;
                sbuf   <= '0;
`endif
            end
        end
    end

    assign rot_val   = op_rot ? {sbuf[2], sbuf[1], sbuf[0], sbuf[3]} : sbuf;
    assign bus.ready = (state == ST_DONE) && !bus.flush;
    assign fsm_state = state;

`ifdef XC_AESSUB_SEQ_RESULT_CLEAR_EN
    assign bus.result = bus.ready ? rot_val : 32'h0;
`else
    assign bus.result = rot_val;
`endif

endmodule
